// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared types, sizes, stage table and register map for the bitonic sorter
package bitonic_pkg;

  localparam int N      = 8;
  localparam int STAGES = 6;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SORT
  } state_t;

  typedef struct packed {
    logic [2:0] lo;
    logic [2:0] hi;
    logic       up;
  } cx_t;

  // Classic 8-input bitonic network; up = 1 puts the smaller word at index lo.
  localparam cx_t STAGE_TABLE [STAGES][4] = '{
    '{ '{3'd0, 3'd1, 1'b1}, '{3'd2, 3'd3, 1'b0}, '{3'd4, 3'd5, 1'b1}, '{3'd6, 3'd7, 1'b0} },
    '{ '{3'd0, 3'd2, 1'b1}, '{3'd1, 3'd3, 1'b1}, '{3'd4, 3'd6, 1'b0}, '{3'd5, 3'd7, 1'b0} },
    '{ '{3'd0, 3'd1, 1'b1}, '{3'd2, 3'd3, 1'b1}, '{3'd4, 3'd5, 1'b0}, '{3'd6, 3'd7, 1'b0} },
    '{ '{3'd0, 3'd4, 1'b1}, '{3'd1, 3'd5, 1'b1}, '{3'd2, 3'd6, 1'b1}, '{3'd3, 3'd7, 1'b1} },
    '{ '{3'd0, 3'd2, 1'b1}, '{3'd1, 3'd3, 1'b1}, '{3'd4, 3'd6, 1'b1}, '{3'd5, 3'd7, 1'b1} },
    '{ '{3'd0, 3'd1, 1'b1}, '{3'd2, 3'd3, 1'b1}, '{3'd4, 3'd5, 1'b1}, '{3'd6, 3'd7, 1'b1} }
  };

  // Word offsets (byte offset >> 2) within the 4 KB window.
  localparam logic [9:0] CTRL_OFS   = 10'h000;
  localparam logic [9:0] STATUS_OFS = 10'h001;
  localparam logic [9:0] IN_OFS     = 10'h004;
  localparam logic [9:0] OUT_OFS    = 10'h084;

endpackage

// File: rtl/bitonic_sort_slave_stage.sv
// rtl/bitonic_sort_slave_stage.sv - combinational compare-exchange layer for one network stage
module bitonic_stage
  import bitonic_pkg::*;
(
  input  word_t [N-1:0] data_in,
  input  logic [2:0]    stage,
  input  logic          desc,
  output word_t [N-1:0] data_out
);

  cx_t   cx;
  word_t a;
  word_t b;
  logic  asc;

  // The four pairs of a stage are disjoint, so all reads come from data_in.
  always_comb begin
    data_out = data_in;
    cx       = '0;
    a        = '0;
    b        = '0;
    asc      = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cx  = STAGE_TABLE[stage][p];
      a   = data_in[cx.lo];
      b   = data_in[cx.hi];
      asc = cx.up ^ desc;
      if (asc ? (a > b) : (a < b)) begin
        data_out[cx.lo] = b;
        data_out[cx.hi] = a;
      end
    end
  end

endmodule

// File: rtl/bitonic_sort_slave.sv
// rtl/bitonic_sort_slave.sv - bus-mapped 8-word iterative bitonic sorter; BITONIC_SORT_DESC_EN enables descending mode
module bitonic_sort_slave
  import bitonic_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h00001000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        done_o
);

  state_t        state_q, state_d;
  logic [2:0]    stage_q, stage_d;
  word_t [N-1:0] in_q, work_q, out_q, stage_out;
  word_t         rdata_q, rdata_d;
  logic          done_q, done_pulse_q, resp_q;
  logic          in_win, wr, rd, busy, start, desc;
  logic          load_work, step, finish;
  logic          is_ctrl, is_status, is_in, is_out;
  logic [9:0]    off;
  logic [2:0]    idx;
  logic          unused_addr;

  assign in_win    = (bus_addr_bi[31:12] == BASE_ADDR[31:12]);
  assign bus_ack_o = bus_req_i & in_win;
  assign wr        = bus_ack_o & bus_we_i;
  assign rd        = bus_ack_o & ~bus_we_i;
  assign off       = bus_addr_bi[11:2];
  assign unused_addr = ^bus_addr_bi[1:0];

  assign is_ctrl   = (off == CTRL_OFS);
  assign is_status = (off == STATUS_OFS);
  assign is_in     = (off >= IN_OFS)  && (off < IN_OFS + 10'(N));
  assign is_out    = (off >= OUT_OFS) && (off < OUT_OFS + 10'(N));
  // Both arrays start at word offset 4 mod 8, so the element index is off[2:0] - 4.
  assign idx       = off[2:0] + 3'd4;

  assign busy  = (state_q != ST_IDLE);
  assign start = wr & is_ctrl & bus_wdata_bi[0] & ~busy;

`ifdef BITONIC_SORT_DESC_EN
  logic desc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)      desc_q <= 1'b0;
    else if (start) desc_q <= bus_wdata_bi[1];
  end
  assign desc = desc_q;
`else
  assign desc = 1'b0;
`endif

  bitonic_stage u_stage (
    .data_in  (work_q),
    .stage    (stage_q),
    .desc     (desc),
    .data_out (stage_out)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    load_work = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        load_work = 1'b1;
        stage_d   = '0;
        state_d   = ST_SORT;
      end
      ST_SORT: begin
        step    = 1'b1;
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'(STAGES - 1)) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (is_ctrl)        rdata_d = {30'b0, desc, 1'b0};
    else if (is_status) rdata_d = {30'b0, done_q, busy};
    else if (is_in)     rdata_d = in_q[idx];
    else if (is_out)    rdata_d = out_q[idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q         <= '0;
      work_q       <= '0;
      out_q        <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      resp_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      done_pulse_q <= finish;
      resp_q       <= rd;
      rdata_q      <= rd ? rdata_d : '0;
      if (wr && is_in && !busy) begin
        for (int b = 0; b < 4; b++) begin
          if (bus_be_bi[b]) in_q[idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
        end
      end
      if (load_work) begin
        work_q <= in_q;
        done_q <= 1'b0;
      end
      if (step) work_q <= stage_out;
      // The final stage result lands in out_q in one shot.
      if (finish) begin
        out_q  <= stage_out;
        done_q <= 1'b1;
      end
    end
  end

  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign done_o       = done_pulse_q;

endmodule

// File: tb/tb_bitonic_sort_slave.sv
// tb/tb_bitonic_sort_slave.sv - randomized self-checking bench for bitonic_sort_slave
module tb_bitonic_sort_slave;

  localparam logic [31:0] BASE = 32'h00001000;
  typedef logic [31:0] arr8_t [8];

  logic        clk = 1'b0, rst = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, resp, done;
  logic [31:0] rdata;

  int checks = 0, failures = 0;
  int cyc = 0, done_count = 0, last_done = 0, wr_cyc = 0;

  bitonic_sort_slave #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
    .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
    .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) begin
    done_count <= done_count + 1;
    last_done  <= cyc;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b; wr_cyc = cyc;
    @(posedge clk); #1; req = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic r, output logic k);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
    #1 k = ack;
    @(posedge clk); #1; req = 1'b0; r = resp; d = rdata;
  endtask

  // Reference: plain insertion sort on unsigned words.
  task automatic model_sort(input arr8_t a, input bit dsc, output arr8_t r);
    logic [31:0] key;
    int j;
    r = a;
    for (int i = 1; i < 8; i++) begin
      key = r[i];
      j = i - 1;
      while (j >= 0 && (dsc ? (r[j] < key) : (r[j] > key))) begin
        r[j+1] = r[j];
        j--;
      end
      r[j+1] = key;
    end
  endtask

  task automatic run_sort(input arr8_t v, input logic [31:0] ctrl, output arr8_t got, output int lat);
    int base, start_cyc;
    logic [31:0] d;
    logic r, k;
    for (int i = 0; i < 8; i++) bus_write(BASE + 32'h10 + 32'(4*i), v[i], 4'hF);
    base = done_count;
    bus_write(BASE, ctrl, 4'hF);
    start_cyc = wr_cyc;
    lat = -1;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (done_count != base) begin
        lat = last_done - start_cyc;
        break;
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'h210 + 32'(4*i), d, r, k);
      got[i] = d;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic r, k;
    do_reset();
    checks++;
    if (resp !== 1'b0 || rdata !== 32'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs resp=%b rdata=%h done=%b required 0/0/0", resp, rdata, done);
    end
    bus_read(BASE + 32'h4, d, r, k);
    checks++;
    if (d !== 32'h0 || r !== 1'b1) begin
      failures++;
      $display("FAIL reset_status got=%h resp=%b required 0 resp=1", d, r);
    end
    bus_read(BASE, d, r, k);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h required 0", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'h210 + 32'(4*i), d, r, k);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_out[%0d] got=%h required 0", i, d); end
    end
  endtask

  task automatic test_reverse();
    arr8_t v, got;
    int lat, base;
    logic [31:0] d;
    logic r, k;
    for (int i = 0; i < 8; i++) v[i] = 32'(8 - i);
    base = done_count;
    run_sort(v, 32'h1, got, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL rev_latency got=%0d required 8", lat); end
    checks++;
    if (done_count - base !== 1) begin failures++; $display("FAIL rev_pulses got=%0d required 1", done_count - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin failures++; $display("FAIL rev_out[%0d] got=%h required %h", i, got[i], 32'(i + 1)); end
    end
    bus_read(BASE + 32'h4, d, r, k);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rev_status got=%h required 2", d); end
  endtask

  task automatic test_duplicates();
    arr8_t v, got, exp;
    int lat;
    v = '{32'h5, 32'hFFFFFFFF, 32'h0, 32'h5, 32'h80000000, 32'h1, 32'h0, 32'h7};
    exp = '{32'h0, 32'h0, 32'h1, 32'h5, 32'h5, 32'h7, 32'h80000000, 32'hFFFFFFFF};
    run_sort(v, 32'h1, got, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin failures++; $display("FAIL dup_out[%0d] got=%h required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    arr8_t v, got, exp;
    int lat;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) v[i] = (n % 2 == 0) ? $urandom() : $urandom_range(0, 3) << 30;
      model_sort(v, 1'b0, exp);
      run_sort(v, 32'h1, got, lat);
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL rand_latency[%0d] got=%0d required 8", n, lat); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin failures++; $display("FAIL rand_out[%0d][%0d] got=%h required %h", n, i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_busy();
    arr8_t v, exp;
    int base, start_cyc, lat;
    logic [31:0] d;
    logic r, k;
    for (int i = 0; i < 8; i++) begin
      v[i] = $urandom();
      bus_write(BASE + 32'h10 + 32'(4*i), v[i], 4'hF);
    end
    model_sort(v, 1'b0, exp);
    base = done_count;
    bus_write(BASE, 32'h1, 4'hF);
    start_cyc = wr_cyc;
    bus_write(BASE + 32'h10, 32'd99, 4'hF);
    bus_write(BASE, 32'h1, 4'hF);
    bus_read(BASE + 32'h4, d, r, k);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL busy_status got=%h required 1", d); end
    lat = -1;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (done_count != base) begin lat = last_done - start_cyc; break; end
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL busy_latency got=%0d required 8", lat); end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done_count - base !== 1) begin failures++; $display("FAIL busy_pulses got=%0d required 1", done_count - base); end
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'h210 + 32'(4*i), d, r, k);
      checks++;
      if (d !== exp[i]) begin failures++; $display("FAIL busy_out[%0d] got=%h required %h", i, d, exp[i]); end
    end
    bus_read(BASE + 32'h10, d, r, k);
    checks++;
    if (d !== v[0]) begin failures++; $display("FAIL busy_in0 got=%h required %h", d, v[0]); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [31:0] d;
    logic r, k;
    for (int i = 0; i < 8; i++) bus_write(BASE + 32'h10 + 32'(4*i), $urandom() | 32'h1, 4'hF);
    base = done_count;
    bus_write(BASE, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = BASE + 32'h4;
    @(posedge clk); #1;
    checks++;
    if (resp !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL midrst_resp_dropped resp=%b rdata=%h required 0/0", resp, rdata);
    end
    rst = 1'b0; req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_count !== base) begin failures++; $display("FAIL midrst_pulses got=%0d required %0d", done_count, base); end
    bus_read(BASE + 32'h4, d, r, k);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL midrst_status got=%h required 0", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'h210 + 32'(4*i), d, r, k);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL midrst_out[%0d] got=%h required 0", i, d); end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d, cur, nd, exp;
    logic [3:0] b;
    logic r, k;
    bus_write(BASE + 32'h10, 32'h11223344, 4'hF);
    bus_write(BASE + 32'h10, 32'hAABBCCDD, 4'b0001);
    bus_read(BASE + 32'h10, d, r, k);
    checks++;
    if (d !== 32'h112233DD) begin failures++; $display("FAIL be_in0 got=%h required 112233dd", d); end
    for (int n = 0; n < 4; n++) begin
      cur = $urandom(); nd = $urandom(); b = 4'($urandom_range(0, 15));
      exp = cur;
      for (int j = 0; j < 4; j++) if (b[j]) exp[8*j +: 8] = nd[8*j +: 8];
      bus_write(BASE + 32'h10 + 32'(4*(n + 3)), cur, 4'hF);
      bus_write(BASE + 32'h10 + 32'(4*(n + 3)), nd, b);
      bus_read(BASE + 32'h10 + 32'(4*(n + 3)), d, r, k);
      checks++;
      if (d !== exp) begin failures++; $display("FAIL be_rand[%0d] got=%h required %h", n, d, exp); end
    end
    bus_read(BASE + 32'h100, d, r, k);
    checks++;
    if (r !== 1'b1 || d !== 32'h0 || k !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_read ack=%b resp=%b rdata=%h required 1/1/0", k, r, d);
    end
    bus_read(32'h00002010, d, r, k);
    checks++;
    if (k !== 1'b0 || r !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL outside_window ack=%b resp=%b rdata=%h required 0/0/0", k, r, d);
    end
  endtask

  task automatic test_direction();
    arr8_t v, got, exp;
    int lat;
    logic [31:0] d, exp_ctrl;
    logic r, k;
    for (int i = 0; i < 8; i++) v[i] = $urandom();
`ifdef BITONIC_SORT_DESC_EN
    model_sort(v, 1'b1, exp);
    exp_ctrl = 32'h2;
`else
    model_sort(v, 1'b0, exp);
    exp_ctrl = 32'h0;
`endif
    run_sort(v, 32'h3, got, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin failures++; $display("FAIL dir_out[%0d] got=%h required %h", i, got[i], exp[i]); end
    end
    bus_read(BASE, d, r, k);
    checks++;
    if (d !== exp_ctrl) begin failures++; $display("FAIL dir_ctrl got=%h required %h", d, exp_ctrl); end
    model_sort(v, 1'b0, exp);
    run_sort(v, 32'h1, got, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin failures++; $display("FAIL dir_asc_out[%0d] got=%h required %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_duplicates();
    test_random();
    test_busy();
    test_byte_enable();
    test_direction();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
